// File: rtl/stb_drain_arbiter.sv
// stb_drain_arbiter: drains store-buffer entries to the dcache ahead of LSU loads.
// Optional ack watchdog enabled by defining STB_DRAIN_TIMEOUT_EN.
module stb_drain_arbiter #(
    parameter int DCACHE_ADDR_WIDTH = 32,
    parameter int DCACHE_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stb_empty_i,
    input  logic [DCACHE_ADDR_WIDTH-1:0] stb_addr_i,
    input  logic [DCACHE_DATA_WIDTH-1:0] stb_wdata_i,
    input  logic [3:0]                   stb_sel_byte_i,
    output logic                         stb_rd_en_o,
    input  logic                         ld_req_i,
    input  logic [DCACHE_ADDR_WIDTH-1:0] ld_addr_i,
    input  logic                         dmem_sel_i,
    output logic                         ld_ack_o,
    output logic [DCACHE_DATA_WIDTH-1:0] ld_rdata_o,
    output logic                         ld_stall_o,
    output logic                         dcache_req_o,
    output logic                         dcache_w_en_o,
    output logic [DCACHE_ADDR_WIDTH-1:0] dcache_addr_o,
    output logic [DCACHE_DATA_WIDTH-1:0] dcache_wdata_o,
    output logic [3:0]                   dcache_sel_byte_o,
    output logic                         dmem_sel_o,
    input  logic                         dcache_ack_i,
    input  logic [DCACHE_DATA_WIDTH-1:0] dcache_rdata_i,
    output logic                         timeout_o
);
    typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT} state_t;
    state_t state, state_nxt;
    logic   timeout_hit;

`ifdef STB_DRAIN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // Counter is zero in the first wait cycle, so expiry lands on wait cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
    end
    assign timeout_hit = (state != IDLE) & !dcache_ack_i & (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stb_rd_en_o = 1'b0;
        ld_ack_o    = 1'b0;
        ld_rdata_o  = '0;
        if (state == IDLE)
            state_nxt = !stb_empty_i ? ST_WAIT : (ld_req_i & dmem_sel_i) ? LD_WAIT : IDLE;
        else if (dcache_ack_i | timeout_hit)
            state_nxt = IDLE;
        stb_rd_en_o = (state == ST_WAIT) & dcache_ack_i;
        ld_ack_o    = (state == LD_WAIT) & dcache_ack_i;
        ld_rdata_o  = ld_ack_o ? dcache_rdata_i : '0;
    end

    assign ld_stall_o = rst_n & ld_req_i & dmem_sel_i & !((state == LD_WAIT) & dcache_ack_i);
    assign dmem_sel_o = dcache_req_o;
    assign timeout_o  = timeout_hit;

    // Request fields are captured only when leaving IDLE, so input changes mid-flight are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcache_req_o      <= 1'b0;
            dcache_w_en_o     <= 1'b0;
            dcache_addr_o     <= '0;
            dcache_wdata_o    <= '0;
            dcache_sel_byte_o <= '0;
        end else if (state == IDLE && state_nxt == ST_WAIT) begin
            dcache_req_o      <= 1'b1;
            dcache_w_en_o     <= 1'b1;
            dcache_addr_o     <= stb_addr_i;
            dcache_wdata_o    <= stb_wdata_i;
            dcache_sel_byte_o <= stb_sel_byte_i;
        end else if (state == IDLE && state_nxt == LD_WAIT) begin
            dcache_req_o      <= 1'b1;
            dcache_w_en_o     <= 1'b0;
            dcache_addr_o     <= ld_addr_i;
            dcache_wdata_o    <= '0;
            dcache_sel_byte_o <= 4'hF;
        end else if (state_nxt == IDLE) begin
            dcache_req_o      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stb_drain_arbiter.sv
// tb_stb_drain_arbiter: directed self-checking bench for stb_drain_arbiter.
// Inputs change 2 time units after posedge; outputs sampled 1 unit later.
module tb_stb_drain_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb_empty_i = 1'b1;
    logic [31:0] stb_addr_i = '0;
    logic [31:0] stb_wdata_i = '0;
    logic [3:0]  stb_sel_byte_i = '0;
    logic        stb_rd_en_o;
    logic        ld_req_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic        dmem_sel_i = 1'b0;
    logic        ld_ack_o;
    logic [31:0] ld_rdata_o;
    logic        ld_stall_o;
    logic        dcache_req_o;
    logic        dcache_w_en_o;
    logic [31:0] dcache_addr_o;
    logic [31:0] dcache_wdata_o;
    logic [3:0]  dcache_sel_byte_o;
    logic        dmem_sel_o;
    logic        dcache_ack_i = 1'b0;
    logic [31:0] dcache_rdata_i = '0;
    logic        timeout_o;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stb_drain_arbiter #(.DCACHE_ADDR_WIDTH(32), .DCACHE_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .stb_empty_i(stb_empty_i), .stb_addr_i(stb_addr_i),
        .stb_wdata_i(stb_wdata_i), .stb_sel_byte_i(stb_sel_byte_i), .stb_rd_en_o(stb_rd_en_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .dmem_sel_i(dmem_sel_i), .ld_ack_o(ld_ack_o),
        .ld_rdata_o(ld_rdata_o), .ld_stall_o(ld_stall_o), .dcache_req_o(dcache_req_o),
        .dcache_w_en_o(dcache_w_en_o), .dcache_addr_o(dcache_addr_o), .dcache_wdata_o(dcache_wdata_o),
        .dcache_sel_byte_o(dcache_sel_byte_o), .dmem_sel_o(dmem_sel_o), .dcache_ack_i(dcache_ack_i),
        .dcache_rdata_i(dcache_rdata_i), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req_chk(input string tag, input logic req, input logic w_en,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
        chk({tag, "_req"}, 64'(dcache_req_o), 64'(req));
        chk({tag, "_dmem"}, 64'(dmem_sel_o), 64'(req));
        chk({tag, "_wen"}, 64'(dcache_w_en_o), 64'(w_en));
        chk({tag, "_addr"}, 64'(dcache_addr_o), 64'(addr));
        chk({tag, "_wdata"}, 64'(dcache_wdata_o), 64'(wdata));
        chk({tag, "_sel"}, 64'(dcache_sel_byte_o), 64'(sel));
    endtask

    initial begin
        ld_req_i = 1'b1;
        dmem_sel_i = 1'b1;
        #1;
        req_chk("rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("rst_pop", 64'(stb_rd_en_o), 64'(0));
        chk("rst_ldack", 64'(ld_ack_o), 64'(0));
        chk("rst_stall", 64'(ld_stall_o), 64'(0));
        chk("rst_to", 64'(timeout_o), 64'(0));
        ld_req_i = 1'b0;
        dmem_sel_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req_chk("idle", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        // Single store, ack three cycles after req
        stb_empty_i = 1'b0; stb_addr_i = 32'h100; stb_wdata_i = 32'hDEADBEEF; stb_sel_byte_i = 4'hF;
        #1;
        chk("s1_pre_req", 64'(dcache_req_o), 64'(0));
        tick();
        req_chk("s1", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        tick();
        tick();
        chk("s1_nopop", 64'(stb_rd_en_o), 64'(0));
        tick();
        dcache_ack_i = 1'b1;
        #1;
        chk("s1_pop", 64'(stb_rd_en_o), 64'(1));
        req_chk("s1_ack", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        chk("s1_noldack", 64'(ld_ack_o), 64'(0));
        tick();
        dcache_ack_i = 1'b0; stb_empty_i = 1'b1;
        #1;
        chk("s1_done_req", 64'(dcache_req_o), 64'(0));
        chk("s1_done_pop", 64'(stb_rd_en_o), 64'(0));
        // Load with empty store buffer
        ld_req_i = 1'b1; dmem_sel_i = 1'b1; ld_addr_i = 32'h200;
        #1;
        chk("l1_stall", 64'(ld_stall_o), 64'(1));
        tick();
        req_chk("l1", 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        dcache_ack_i = 1'b1; dcache_rdata_i = 32'h12345678;
        #1;
        chk("l1_ack", 64'(ld_ack_o), 64'(1));
        chk("l1_rdata", 64'(ld_rdata_o), 64'(32'h12345678));
        chk("l1_stall_ack", 64'(ld_stall_o), 64'(0));
        chk("l1_nopop", 64'(stb_rd_en_o), 64'(0));
        tick();
        ld_req_i = 1'b0; dmem_sel_i = 1'b0; dcache_ack_i = 1'b0;
        #1;
        chk("l1_done_req", 64'(dcache_req_o), 64'(0));
        chk("l1_done_ack", 64'(ld_ack_o), 64'(0));
        chk("l1_rdata_zero", 64'(ld_rdata_o), 64'(0));
        // Two stores drain before a pending load
        stb_empty_i = 1'b0; stb_addr_i = 32'h300; stb_wdata_i = 32'hAAAA0001; stb_sel_byte_i = 4'h3;
        ld_req_i = 1'b1; dmem_sel_i = 1'b1; ld_addr_i = 32'h400;
        tick();
        req_chk("s2a", 1'b1, 1'b1, 32'h300, 32'hAAAA0001, 4'h3);
        chk("s2a_stall", 64'(ld_stall_o), 64'(1));
        dcache_ack_i = 1'b1;
        stb_addr_i = 32'h304; stb_wdata_i = 32'hBBBB0002; stb_sel_byte_i = 4'hC;
        #1;
        chk("s2a_pop", 64'(stb_rd_en_o), 64'(1));
        chk("s2a_hold_addr", 64'(dcache_addr_o), 64'(32'h300));
        chk("s2a_stall_ack", 64'(ld_stall_o), 64'(1));
        tick();
        dcache_ack_i = 1'b0;
        #1;
        chk("s2_gap_req", 64'(dcache_req_o), 64'(0));
        chk("s2_gap_stall", 64'(ld_stall_o), 64'(1));
        tick();
        req_chk("s2b", 1'b1, 1'b1, 32'h304, 32'hBBBB0002, 4'hC);
        chk("s2b_stall", 64'(ld_stall_o), 64'(1));
        dcache_ack_i = 1'b1;
        #1;
        chk("s2b_pop", 64'(stb_rd_en_o), 64'(1));
        tick();
        dcache_ack_i = 1'b0; stb_empty_i = 1'b1;
        #1;
        chk("s2b_gap_req", 64'(dcache_req_o), 64'(0));
        tick();
        req_chk("s2l", 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        dcache_ack_i = 1'b1; dcache_rdata_i = 32'hCAFEF00D;
        #1;
        chk("s2l_ack", 64'(ld_ack_o), 64'(1));
        chk("s2l_rdata", 64'(ld_rdata_o), 64'(32'hCAFEF00D));
        tick();
        dcache_ack_i = 1'b0; ld_req_i = 1'b0; dmem_sel_i = 1'b0;
        // Reset in the middle of a store
        stb_empty_i = 1'b0; stb_addr_i = 32'h500; stb_wdata_i = 32'h55; stb_sel_byte_i = 4'h1;
        tick();
        req_chk("r_pre", 1'b1, 1'b1, 32'h500, 32'h55, 4'h1);
        rst_n = 1'b0; dcache_ack_i = 1'b1;
        #1;
        req_chk("r_in", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("r_nopop", 64'(stb_rd_en_o), 64'(0));
        chk("r_noldack", 64'(ld_ack_o), 64'(0));
        tick();
        rst_n = 1'b1; dcache_ack_i = 1'b0;
        tick();
        req_chk("r_post", 1'b1, 1'b1, 32'h500, 32'h55, 4'h1);
        dcache_ack_i = 1'b1;
        #1;
        chk("r_post_pop", 64'(stb_rd_en_o), 64'(1));
        tick();
        dcache_ack_i = 1'b0; stb_empty_i = 1'b1;
        // Spurious ack while idle
        tick();
        dcache_ack_i = 1'b1; dcache_rdata_i = 32'h99999999;
        #1;
        chk("sp_pop", 64'(stb_rd_en_o), 64'(0));
        chk("sp_ldack", 64'(ld_ack_o), 64'(0));
        chk("sp_rdata", 64'(ld_rdata_o), 64'(0));
        tick();
        dcache_ack_i = 1'b0;
        #1;
        chk("sp_req", 64'(dcache_req_o), 64'(0));
        // Store with no ack: watchdog or indefinite wait
        stb_empty_i = 1'b0; stb_addr_i = 32'h600; stb_wdata_i = 32'h66; stb_sel_byte_i = 4'hF;
        tick();
        req_chk("t_req", 1'b1, 1'b1, 32'h600, 32'h66, 4'hF);
        chk("t_first", 64'(timeout_o), 64'(0));
`ifdef STB_DRAIN_TIMEOUT_EN
        for (int i = 0; i < 6; i++) tick();
        chk("t_early", 64'(timeout_o), 64'(0));
        tick();
        chk("t_pulse", 64'(timeout_o), 64'(1));
        chk("t_pulse_req", 64'(dcache_req_o), 64'(1));
        chk("t_nopop", 64'(stb_rd_en_o), 64'(0));
        tick();
        chk("t_idle_req", 64'(dcache_req_o), 64'(0));
        chk("t_idle_to", 64'(timeout_o), 64'(0));
        tick();
        req_chk("t_retry", 1'b1, 1'b1, 32'h600, 32'h66, 4'hF);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("t_hold_req", 64'(dcache_req_o), 64'(1));
        chk("t_none", 64'(timeout_o), 64'(0));
`endif
        dcache_ack_i = 1'b1;
        #1;
        chk("t_pop", 64'(stb_rd_en_o), 64'(1));
        tick();
        dcache_ack_i = 1'b0; stb_empty_i = 1'b1;
        #1;
        chk("t_end_req", 64'(dcache_req_o), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
